// File: rtl/comar_rand_gen.sv
// Fresh-mask generator for 2-share COMAR gadgets: 64-bit Fibonacci LFSR advanced W steps per word.
// Optional repetition health monitor enabled with macro COMAR_RAND_HEALTH_EN.
module comar_rand_gen #(
  parameter int unsigned NUM_GADGETS   = 1,
  parameter int unsigned RESEED_CYCLES = 1024,
  localparam int unsigned W            = 6 * NUM_GADGETS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  seed,
  input  logic         seed_valid,
  output logic         seed_ready,
  input  logic         en,
  output logic [W-1:0] r_out,
  output logic         r_valid,
  output logic         reseed_req,
  output logic         seed_err,
  output logic         alarm
);

  typedef enum logic [1:0] {UNSEEDED, RUN, EXPIRED} fsm_t;

  fsm_t        fsm, fsm_nxt;
  logic [63:0] lfsr_q, lfsr_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        seed_ok, seed_zero, advance, alarm_nxt;

  function automatic logic [63:0] lfsr_adv(input logic [63:0] s);
    logic [63:0] t;
    t = s;
    for (int unsigned i = 0; i < W; i++)
      t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
    return t;
  endfunction

  assign seed_ready = !rst;

  always_comb begin
    seed_ok   = seed_valid && seed_ready && (seed != '0);
    seed_zero = seed_valid && seed_ready && (seed == '0);
    // A handshake takes priority over en, so the seed path never double-advances.
    advance   = (fsm == RUN) && en && !seed_ok;
    lfsr_nxt  = lfsr_adv(seed_ok ? seed : lfsr_q);
    fsm_nxt   = fsm;
    cnt_nxt   = cnt;
    if (seed_ok) begin
      fsm_nxt = RUN;
      cnt_nxt = '0;
    end else if (advance) begin
      cnt_nxt = cnt + 16'd1;
      if (cnt_nxt == 16'(RESEED_CYCLES))
        fsm_nxt = EXPIRED;
    end
  end

`ifdef COMAR_RAND_HEALTH_EN
  logic [2:0] rep_q, rep_nxt;
  logic       alarm_q;

  always_comb begin
    rep_nxt   = rep_q;
    alarm_nxt = alarm_q;
    if (advance) begin
      if (lfsr_nxt[W-1:0] == r_out) begin
        if (rep_q != 3'd4)
          rep_nxt = rep_q + 3'd1;
      end else begin
        rep_nxt = '0;
      end
      if (rep_nxt == 3'd4)
        alarm_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      rep_q   <= rep_nxt;
      alarm_q <= alarm_nxt;
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm_nxt = 1'b0;
  assign alarm     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q     <= '0;
      cnt        <= '0;
      fsm        <= UNSEEDED;
      r_out      <= '0;
      r_valid    <= 1'b0;
      reseed_req <= 1'b0;
      seed_err   <= 1'b0;
    end else begin
      if (seed_ok || advance) begin
        lfsr_q <= lfsr_nxt;
        r_out  <= lfsr_nxt[W-1:0];
      end
      cnt        <= cnt_nxt;
      fsm        <= fsm_nxt;
      r_valid    <= (fsm_nxt == RUN) && !alarm_nxt;
      reseed_req <= (fsm_nxt == EXPIRED);
      seed_err   <= seed_zero;
    end
  end

endmodule

// File: tb/tb_comar_rand_gen.sv
// Self-checking bench for comar_rand_gen against a behavioural word-level model.
module tb_comar_rand_gen;
  localparam int NG = 1;
`ifdef COMAR_RAND_HEALTH_EN
  localparam int RC = 8;
`else
  localparam int RC = 4;
`endif
  localparam int W = 6 * NG;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  seed = '0;
  logic         seed_valid = 1'b0;
  logic         seed_ready;
  logic         en = 1'b0;
  logic [W-1:0] r_out;
  logic         r_valid, reseed_req, seed_err, alarm;

  int vectors = 0;
  int miscompares = 0;

  // Model: phase 0 = unseeded, 1 = producing words, 2 = seed budget spent.
  logic [63:0]  m_state = '0;
  logic [W-1:0] m_rout = '0;
  int           m_cnt = 0, m_phase = 0, m_rep = 0;
  logic         m_err = 1'b0, m_alarm = 1'b0;

  comar_rand_gen #(.NUM_GADGETS(NG), .RESEED_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .seed(seed), .seed_valid(seed_valid),
    .seed_ready(seed_ready), .en(en), .r_out(r_out), .r_valid(r_valid),
    .reseed_req(reseed_req), .seed_err(seed_err), .alarm(alarm)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] adv(input logic [63:0] s);
    logic [63:0] fb;
    for (int k = 0; k < W; k++) begin
      fb = ((s >> 63) ^ (s >> 62) ^ (s >> 60) ^ (s >> 59)) & 64'd1;
      s  = (s << 1) | fb;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic sv, input logic [63:0] sd, input logic e);
    logic [63:0] nst;
    if (r) begin
      m_state = '0; m_rout = '0; m_cnt = 0; m_phase = 0;
      m_err = 1'b0; m_alarm = 1'b0; m_rep = 0;
    end else begin
      m_err = sv && (sd == 64'd0);
      if (sv && sd != 64'd0) begin
        m_state = adv(sd);
        m_rout  = m_state[W-1:0];
        m_cnt   = 0;
        m_phase = 1;
      end else if (m_phase == 1 && e) begin
        nst = adv(m_state);
`ifdef COMAR_RAND_HEALTH_EN
        if (nst[W-1:0] == m_rout) m_rep++;
        else m_rep = 0;
        if (m_rep >= 4) m_alarm = 1'b1;
`endif
        m_state = nst;
        m_rout  = nst[W-1:0];
        m_cnt++;
        if (m_cnt == RC) m_phase = 2;
      end
    end
  endtask

  task automatic step(input logic r, input logic sv, input logic [63:0] sd, input logic e);
    rst = r; seed_valid = sv; seed = sd; en = e;
    @(posedge clk);
    model(r, sv, sd, e);
    #1;
    chk("r_out",      64'(r_out),      64'(m_rout));
    chk("r_valid",    64'(r_valid),    64'(m_phase == 1 && !m_alarm));
    chk("reseed_req", 64'(reseed_req), 64'(m_phase == 2));
    chk("seed_err",   64'(seed_err),   64'(m_err));
    chk("alarm",      64'(alarm),      64'(m_alarm));
    chk("seed_ready", 64'(seed_ready), 64'(!r));
  endtask

  function automatic logic [63:0] rnd_seed();
    return {$urandom, $urandom} | 64'd1;
  endfunction

  initial begin
    int advs;
    // Reset overrides a concurrent handshake and en.
    step(1'b1, 1'b1, 64'h1234, 1'b1);
    step(1'b1, 1'b0, 64'h0, 1'b0);

    // Zero seed while unseeded: one-cycle error, nothing else changes.
    step(1'b0, 1'b1, 64'h0, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    chk("unseeded_hold", 64'(r_valid), 64'd0);

    // Seed 1: after six steps the state is 64'h40, so r_out[5:0] is zero.
    step(1'b0, 1'b1, 64'h1, 1'b0);
    chk("seed1_state", m_state, 64'h40);
    step(1'b0, 1'b0, 64'h0, 1'b0);

    // Budget exhaustion with en held high, then hold and recovery.
    step(1'b0, 1'b1, 64'hDEADBEEF_CAFEF00D, 1'b1);
    for (int i = 0; i < RC + 2; i++) step(1'b0, 1'b0, 64'h0, 1'b1);
    chk("expired", 64'(reseed_req), 64'd1);
    step(1'b0, 1'b1, 64'h0, 1'b1);
    step(1'b0, 1'b1, rnd_seed(), 1'b0);
    chk("reseeded", 64'(r_valid), 64'd1);

    // Handshake and en together: load only, no extra advance.
    step(1'b0, 1'b0, 64'h0, 1'b1);
    step(1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1);
    chk("hs_wins_cnt", 64'(m_cnt), 64'd0);
    step(1'b0, 1'b0, 64'h0, 1'b1);

    // Random traffic with occasional (sometimes zero) seeds.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(9) == 0)
        step(1'b0, 1'b1, ($urandom_range(2) == 0) ? 64'h0 : rnd_seed(), 1'($urandom_range(1)));
      else
        step(1'b0, 1'b0, 64'h0, 1'($urandom_range(1)));
    end

    // Ten advances, reseeding as needed, then reset discards everything.
    advs = 0;
    for (int i = 0; i < 40 && advs < 10; i++) begin
      if (m_phase != 1) step(1'b0, 1'b1, rnd_seed(), 1'b0);
      else begin
        step(1'b0, 1'b0, 64'h0, 1'b1);
        advs++;
      end
    end
    chk("ten_advances", 64'(advs), 64'd10);
    step(1'b1, 1'b0, 64'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'h0, 1'b1);

`ifdef COMAR_RAND_HEALTH_EN
    // Zeroed state and output repeat forever; alarm must latch and gate r_valid.
    step(1'b0, 1'b1, rnd_seed(), 1'b0);
    dut.lfsr_q = '0;
    dut.r_out  = '0;
    m_state = '0;
    m_rout  = '0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 64'h0, 1'b1);
    chk("alarm_set", 64'(alarm), 64'd1);
    step(1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b1, 1'b0, 64'h0, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
